ram_ctrl_verilog: RTL and testbench
===================================

Name: ram_ctrl_verilog

Overview:
- Parametrised successor to the processor's opcode-decoded data RAM.
- Generalised in DATA_WIDTH and DEPTH; sits on the shared opcode/operand bus beside the ROM and ALU/REG blocks.
- Adds a registered read port with a read_valid strobe.
- Adds a multi-cycle hardware clear sequence (RAM_CLEAR) with a busy indication.

Parameters:
- DATA_WIDTH, 16, width of opcode, operand, write_data, read_data and of each RAM word; minimum 16.
- DEPTH, 256, number of RAM words; need not be a power of two.
- ADDR_WIDTH, 8, address bits, equal to ceil(log2(DEPTH)); must be <= DATA_WIDTH-8.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- opcode  input  DATA_WIDTH  top nibble is select (RAM_OP=4'h4, ROM_OP=4'h3, REG_OP=4'h9); next nibble is operation (WRITE=1, READ=2, CLEAR=3).
- operand  input  DATA_WIDTH  address source, and write data for RAM_OP WRITE.
- write_data  input  DATA_WIDTH  write data for ROM_OP/REG_OP WRITE.
- read_enable  input  1  qualifies READ operations.
- write_enable  input  1  qualifies WRITE and CLEAR operations.
- read_data  output  DATA_WIDTH  registered read result; holds its value between reads.
- read_valid  output  1  one-cycle pulse, high in the cycle after a read is accepted.
- busy  output  1  high while a clear sequence runs.
- addr_error  output  1  only present with RAM_BOUNDS_CHECK_EN.

Behaviour:
- Reset (asserted low, asynchronous):
  - read_data=0, read_valid=0, busy=0, FSM=IDLE, clear counter=0, addr_error=0.
  - RAM array contents are not reset.
- Address selection:
  - ROM_OP uses opcode[ADDR_WIDTH-1:0].
  - All other selects use operand[ADDR_WIDTH-1:0].
- Writes (IDLE only, write_enable=1, synchronous at the clock edge):
  - {RAM_OP,WRITE} stores operand.
  - {ROM_OP,WRITE} and {REG_OP,WRITE} store write_data.
  - Any other opcode with write_enable=1 writes nothing.
- Reads (IDLE only, read_enable=1):
  - Accepted when opcode[DATA_WIDTH-1:DATA_WIDTH-8] is 8'h42 or 8'h92.
  - Read latency is 1: for a read accepted at edge N, read_data updates at edge N and read_valid is high for exactly one cycle after edge N.
  - Back-to-back reads give one valid pulse per read.
- Read-after-write:
  - A read in the cycle after a write to the same address returns the new data.
  - A read opcode with write_enable also high performs only the read.
- FSM states:
  - IDLE: {RAM_OP,CLEAR} with write_enable=1 moves to CLEAR; counter=0, busy=1 from the next cycle.
  - CLEAR: each cycle writes 0 to ram[counter] and increments the counter. After writing DEPTH-1, return to IDLE; busy drops in the cycle after the last write. The clear takes exactly DEPTH cycles.
- During CLEAR:
  - All bus reads and writes are ignored; read_valid stays 0 and read_data holds.
  - A further CLEAR request is ignored.
- Reset mid-clear aborts immediately: busy=0, FSM=IDLE; words not yet cleared keep their old values.
- Address >= DEPTH without RAM_BOUNDS_CHECK_EN: the access is dropped (no write; a read returns 0 with a valid pulse). The clear counter never exceeds DEPTH-1.

Optional Feature:
- Macro: RAM_BOUNDS_CHECK_EN.
- Defined:
  - The addr_error port exists.
  - A write or read to an address >= DEPTH, or with address-source bits above ADDR_WIDTH non-zero (operand[DATA_WIDTH-1:ADDR_WIDTH] for RAM_OP/REG_OP; opcode[7:ADDR_WIDTH] for ROM_OP when ADDR_WIDTH<8), is rejected.
  - Rejection: no write; no read_valid; read_data holds.
  - addr_error is registered and high for one cycle after the rejected edge.
- Undefined:
  - No addr_error port.
  - Upper address bits are ignored (truncation); out-of-range handling is as in Behaviour.

Test Plan:
- Reset check: hold reset=0 for 2 cycles, release -> read_data=0, read_valid=0, busy=0.
- Write then read: opcode=16'h4100 with operand=16'h0005 and write_enable=1; next cycle opcode=16'h4200, operand=16'h0005, read_enable=1 -> next cycle read_data=16'h0005, read_valid=1 for 1 cycle.
- ROM and REG writes: opcode=16'h3123, write_data=16'hBEEF (write to 0x23); then opcode=16'h9100, operand=16'h0040, write_data=16'h1234 -> read opcode=16'h9200 returns 16'hBEEF at operand=16'h0023 and 16'h1234 at operand=16'h0040.
- Clear: fill addresses 0, 100 and 255 with 16'hFFFF; issue opcode=16'h4300 with write_enable=1 -> busy high for exactly 256 cycles; a read attempted mid-clear gives no read_valid; after the clear, all three addresses read 16'h0000.
- Reset mid-clear: with addresses 0 and 200 preset to 16'hAAAA, start a clear and assert reset at cycle 10 -> busy=0 immediately; address 0 reads 0; address 200 still reads 16'hAAAA.
- Bounds (with RAM_BOUNDS_CHECK_EN, DEPTH=200): write to operand=16'h00C8 -> addr_error pulses 1 cycle; reading 16'h00C8 gives no read_valid; address 0xC7 is still writable and readable.

Source files
------------

// File: rtl/ram_ctrl_verilog_if.sv
// Opcode/operand bus between the processor core and the parametrised data RAM.
// With RAM_BOUNDS_CHECK_EN defined the bus also carries the addr_error strobe.
interface ram_ctrl_verilog_if #(
  parameter int DATA_WIDTH = 16
);
  logic [DATA_WIDTH-1:0] opcode;
  logic [DATA_WIDTH-1:0] operand;
  logic [DATA_WIDTH-1:0] write_data;
  logic                  read_enable;
  logic                  write_enable;
  logic [DATA_WIDTH-1:0] read_data;
  logic                  read_valid;
  logic                  busy;
`ifdef RAM_BOUNDS_CHECK_EN
  logic                  addr_error;

  modport master (
    output opcode, operand, write_data, read_enable, write_enable,
    input  read_data, read_valid, busy, addr_error
  );
  modport slave (
    input  opcode, operand, write_data, read_enable, write_enable,
    output read_data, read_valid, busy, addr_error
  );
`else
  modport master (
    output opcode, operand, write_data, read_enable, write_enable,
    input  read_data, read_valid, busy
  );
  modport slave (
    input  opcode, operand, write_data, read_enable, write_enable,
    output read_data, read_valid, busy
  );
`endif
endinterface

// File: rtl/ram_ctrl_verilog.sv
// Opcode-decoded data RAM with registered read port and hardware clear sequence.
// Optional macro RAM_BOUNDS_CHECK_EN rejects out-of-range accesses and adds addr_error.
module ram_ctrl_verilog #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 256,
  parameter int ADDR_WIDTH = 8
) (
  input  logic              clk,
  input  logic              reset,
  ram_ctrl_verilog_if.slave bus
);
  localparam logic [3:0] SEL_RAM  = 4'h4;
  localparam logic [3:0] SEL_ROM  = 4'h3;
  localparam logic [3:0] SEL_REG  = 4'h9;
  localparam logic [3:0] OP_WRITE = 4'h1;
  localparam logic [3:0] OP_CLEAR = 4'h3;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_CLEAR = 1'b1;

  logic [0:0]            r_state;
  logic [ADDR_WIDTH-1:0] r_clr_cnt;
  logic [DATA_WIDTH-1:0] r_read_data;
  logic                  r_read_valid;
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  logic [3:0]            w_sel;
  logic [3:0]            w_op;
  logic [7:0]            w_rd_code;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic                  w_in_range;
  logic                  w_addr_ok;
  logic                  w_idle;
  logic                  w_wr_req;
  logic                  w_rd_req;
  logic                  w_clr_req;
  logic [DATA_WIDTH-1:0] w_wdata;
  logic [DATA_WIDTH-1:0] w_rd_word;

  assign w_sel     = bus.opcode[DATA_WIDTH-1 -: 4];
  assign w_op      = bus.opcode[DATA_WIDTH-5 -: 4];
  assign w_rd_code = bus.opcode[DATA_WIDTH-1 -: 8];

  // ROM opcodes carry their address in the opcode itself; everything else uses the operand.
  assign w_addr     = (w_sel == SEL_ROM) ? bus.opcode[ADDR_WIDTH-1:0]
                                         : bus.operand[ADDR_WIDTH-1:0];
  assign w_in_range = int'(w_addr) < DEPTH;

`ifdef RAM_BOUNDS_CHECK_EN
  logic w_hi_nz;
  logic r_addr_error;

  assign w_hi_nz   = (w_sel == SEL_ROM) ? ((bus.opcode[7:0] >> ADDR_WIDTH) != '0)
                                        : ((bus.operand >> ADDR_WIDTH) != '0);
  assign w_addr_ok = w_in_range && !w_hi_nz;
  assign bus.addr_error = r_addr_error;
`else
  assign w_addr_ok = w_in_range;
`endif

  assign w_idle    = (r_state == ST_IDLE);
  assign w_wr_req  = w_idle && bus.write_enable && (w_op == OP_WRITE) &&
                     (w_sel == SEL_RAM || w_sel == SEL_ROM || w_sel == SEL_REG);
  assign w_rd_req  = w_idle && bus.read_enable &&
                     (w_rd_code == 8'h42 || w_rd_code == 8'h92);
  assign w_clr_req = w_idle && bus.write_enable && (w_sel == SEL_RAM) && (w_op == OP_CLEAR);
  assign w_wdata   = (w_sel == SEL_RAM) ? bus.operand : bus.write_data;
  assign w_rd_word = w_in_range ? r_mem[w_addr] : '0;

  // NOTE: the array is deliberately left out of reset so it maps onto plain RAM;
  // writes are only gated by reset so an in-flight clear stops on assertion.
  always_ff @(posedge clk) begin
    if (reset) begin
      if (r_state == ST_CLEAR)
        r_mem[r_clr_cnt] <= '0;
      else if (w_wr_req && w_addr_ok)
        r_mem[w_addr] <= w_wdata;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // in this block sees the pre-edge values of its neighbours.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= ST_IDLE;
      r_clr_cnt    <= '0;
      r_read_data  <= '0;
      r_read_valid <= 1'b0;
`ifdef RAM_BOUNDS_CHECK_EN
      r_addr_error <= 1'b0;
`endif
    end else begin
      r_read_valid <= 1'b0;
`ifdef RAM_BOUNDS_CHECK_EN
      r_addr_error <= (w_rd_req || w_wr_req) && !w_addr_ok;
`endif
      case (r_state)
        ST_IDLE: begin
          if (w_clr_req) begin
            r_state   <= ST_CLEAR;
            r_clr_cnt <= '0;
          end
          if (w_rd_req) begin
`ifdef RAM_BOUNDS_CHECK_EN
            if (w_addr_ok) begin
              r_read_data  <= w_rd_word;
              r_read_valid <= 1'b1;
            end
`else
            r_read_data  <= w_rd_word;
            r_read_valid <= 1'b1;
`endif
          end
        end
        ST_CLEAR: begin
          if (int'(r_clr_cnt) == DEPTH - 1) begin
            r_state   <= ST_IDLE;
            r_clr_cnt <= '0;
          end else begin
            r_clr_cnt <= r_clr_cnt + 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.read_data  = r_read_data;
  assign bus.read_valid = r_read_valid;
  assign bus.busy       = (r_state == ST_CLEAR);
endmodule

// File: tb/tb_ram_ctrl_verilog.sv
// Self-checking bench for ram_ctrl_verilog: vector table plus clear/reset/bounds sequences,
// with read results checked through a scoreboard queue.
module tb_ram_ctrl_verilog;
`ifdef RAM_BOUNDS_CHECK_EN
  localparam int DEPTH = 200;
`else
  localparam int DEPTH = 256;
`endif
  localparam int MID = (DEPTH > 200) ? 200 : 150;

  typedef struct {
    logic [15:0] opc;
    logic [15:0] opd;
    logic [15:0] wd;
    logic        re;
    logic        we;
    logic        exp_v;
    logic [15:0] exp_d;
  } vec_t;

  logic clk;
  logic reset;
  ram_ctrl_verilog_if #(.DATA_WIDTH(16)) bus();

  ram_ctrl_verilog #(
    .DATA_WIDTH(16),
    .DEPTH     (DEPTH),
    .ADDR_WIDTH(8)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_errors = 0;
  int          n_pushed = 0;
  int          n_valid  = 0;
  logic [15:0] sb[$];
  logic [15:0] last_rd = '0;
  logic [15:0] mon_exp;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Every valid pulse must match the oldest outstanding expected read.
  always @(negedge clk) begin
    if (reset && bus.read_valid) begin
      n_valid++;
      if (sb.size() == 0) begin
        check("unexpected_read_valid", 1, 0);
      end else begin
        mon_exp = sb.pop_front();
        last_rd = mon_exp;
        check("read_data", bus.read_data, mon_exp);
      end
    end
  end

  task automatic bus_op(input logic [15:0] opc, input logic [15:0] opd, input logic [15:0] wd,
                        input logic re, input logic we);
    bus.opcode       = opc;
    bus.operand      = opd;
    bus.write_data   = wd;
    bus.read_enable  = re;
    bus.write_enable = we;
    @(posedge clk);
    #1;
    bus.read_enable  = 1'b0;
    bus.write_enable = 1'b0;
  endtask

  task automatic rd(input logic [15:0] opc, input logic [15:0] opd, input logic [15:0] exp);
    sb.push_back(exp);
    n_pushed++;
    bus_op(opc, opd, 16'h0000, 1'b1, 1'b0);
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 5 && sb.size() != 0; i++) @(posedge clk);
    @(negedge clk);
    check(name, sb.size(), 0);
  endtask

  vec_t vecs[$];
  int   busy_cnt;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, errors=%0d", n_errors);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    bus.opcode = '0; bus.operand = '0; bus.write_data = '0;
    bus.read_enable = 1'b0; bus.write_enable = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    check("reset_read_data", bus.read_data, 0);
    check("reset_read_valid", bus.read_valid, 0);
    check("reset_busy", bus.busy, 0);
`ifdef RAM_BOUNDS_CHECK_EN
    check("reset_addr_error", bus.addr_error, 0);
`endif
    @(posedge clk); #1;

    // Vector table
    vecs.push_back('{16'h4100, 16'h0005, 16'h0000, 1'b0, 1'b1, 1'b0, 16'h0000});
    vecs.push_back('{16'h4200, 16'h0005, 16'h0000, 1'b1, 1'b0, 1'b1, 16'h0005});
    vecs.push_back('{16'h3123, 16'h0000, 16'hBEEF, 1'b0, 1'b1, 1'b0, 16'h0000});
    vecs.push_back('{16'h9100, 16'h0040, 16'h1234, 1'b0, 1'b1, 1'b0, 16'h0000});
    vecs.push_back('{16'h9200, 16'h0023, 16'h0000, 1'b1, 1'b0, 1'b1, 16'hBEEF});
    vecs.push_back('{16'h9200, 16'h0040, 16'h0000, 1'b1, 1'b0, 1'b1, 16'h1234});
    vecs.push_back('{16'h4200, 16'h0040, 16'h0000, 1'b1, 1'b0, 1'b1, 16'h1234});
    vecs.push_back('{16'h4100, 16'h0077, 16'h0000, 1'b0, 1'b1, 1'b0, 16'h0000});
    vecs.push_back('{16'h4200, 16'h0077, 16'h0000, 1'b1, 1'b0, 1'b1, 16'h0077});
    vecs.push_back('{16'h5100, 16'h0077, 16'hDEAD, 1'b0, 1'b1, 1'b0, 16'h0000});
    vecs.push_back('{16'h4400, 16'h0077, 16'hDEAD, 1'b0, 1'b1, 1'b0, 16'h0000});
    vecs.push_back('{16'h9200, 16'h0077, 16'hDEAD, 1'b1, 1'b1, 1'b1, 16'h0077});
    vecs.push_back('{16'h4200, 16'h0077, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000});
    vecs.push_back('{16'h3200, 16'h0077, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000});
    vecs.push_back('{16'h9200, 16'h0077, 16'h0000, 1'b1, 1'b0, 1'b1, 16'h0077});
    vecs.push_back('{16'h3177, 16'h0000, 16'hCAFE, 1'b0, 1'b1, 1'b0, 16'h0000});
    vecs.push_back('{16'h4200, 16'h0077, 16'h0000, 1'b1, 1'b0, 1'b1, 16'hCAFE});
    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].exp_v) begin
        sb.push_back(vecs[i].exp_d);
        n_pushed++;
      end
      bus_op(vecs[i].opc, vecs[i].opd, vecs[i].wd, vecs[i].re, vecs[i].we);
    end
    drain("table_drain");
    check("read_data_hold", bus.read_data, 16'hCAFE);

    // Upper operand bits: truncated by default, rejected with bounds checking
`ifdef RAM_BOUNDS_CHECK_EN
    bus_op(16'h4100, 16'h0105, 16'h0000, 1'b0, 1'b1);
    @(negedge clk);
    check("hi_bits_addr_error", bus.addr_error, 1);
    rd(16'h4200, 16'h0005, 16'h0005);
`else
    bus_op(16'h4100, 16'h0105, 16'h0000, 1'b0, 1'b1);
    rd(16'h4200, 16'h0005, 16'h0105);
`endif
    drain("trunc_drain");

    // Clear sequence with ignored traffic while busy
    bus_op(16'h9100, 16'h0000, 16'hFFFF, 1'b0, 1'b1);
    bus_op(16'h9100, 16'd100, 16'hFFFF, 1'b0, 1'b1);
    bus_op(16'h9100, 16'(DEPTH - 1), 16'hFFFF, 1'b0, 1'b1);
    bus_op(16'h4300, 16'h0000, 16'h0000, 1'b0, 1'b1);
    busy_cnt = 0;
    for (int i = 0; i < DEPTH + 20; i++) begin
      @(negedge clk);
      if (!bus.busy) break;
      busy_cnt++;
      case (i)
        3: begin
          bus.opcode = 16'h4200; bus.operand = 16'd100; bus.read_enable = 1'b1;
        end
        4: begin
          bus.read_enable = 1'b0;
          bus.opcode = 16'h9100; bus.operand = 16'h0000; bus.write_data = 16'h5555;
          bus.write_enable = 1'b1;
        end
        5: begin
          bus.opcode = 16'h4300; bus.write_enable = 1'b1;
        end
        6: begin
          bus.write_enable = 1'b0;
          check("clear_read_data_hold", bus.read_data, last_rd);
        end
        default: ;
      endcase
    end
    check("clear_busy_cycles", busy_cnt, DEPTH);
    @(posedge clk); #1;
    rd(16'h4200, 16'h0000, 16'h0000);
    rd(16'h4200, 16'd100, 16'h0000);
    rd(16'h4200, 16'(DEPTH - 1), 16'h0000);
    drain("clear_drain");

    // Reset in the middle of a clear
    bus_op(16'h9100, 16'h0000, 16'hAAAA, 1'b0, 1'b1);
    bus_op(16'h9100, 16'(MID), 16'hAAAA, 1'b0, 1'b1);
    bus_op(16'h4300, 16'h0000, 16'h0000, 1'b0, 1'b1);
    repeat (9) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    check("abort_busy", bus.busy, 0);
    check("abort_read_valid", bus.read_valid, 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    check("abort_still_idle", bus.busy, 0);
    rd(16'h4200, 16'h0000, 16'h0000);
    rd(16'h4200, 16'(MID), 16'hAAAA);
    drain("abort_drain");

`ifdef RAM_BOUNDS_CHECK_EN
    // Out-of-range accesses are rejected with a one-cycle addr_error
    bus_op(16'h4100, 16'h00C8, 16'h0000, 1'b0, 1'b1);
    @(negedge clk);
    check("oob_write_addr_error", bus.addr_error, 1);
    @(negedge clk);
    check("oob_addr_error_pulse", bus.addr_error, 0);
    bus_op(16'h4200, 16'h00C8, 16'h0000, 1'b1, 1'b0);
    @(negedge clk);
    check("oob_read_addr_error", bus.addr_error, 1);
    check("oob_read_data_hold", bus.read_data, last_rd);
    bus_op(16'h9100, 16'h00C7, 16'h1357, 1'b0, 1'b1);
    rd(16'h9200, 16'h00C7, 16'h1357);
    drain("bounds_drain");
`endif

    check("valid_pulse_count", n_valid, n_pushed);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
